// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: round-robin between requesters A and B plus a sequenced clear; 1-cycle grant-to-write, all outputs registered.
// Requesters hold REQ/ADDR/DATA until ACK; a clear preempts arbitration and pending requests wait until it completes.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  input  logic              A_REQ,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_ACK,
  input  logic              B_REQ,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_ACK,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic [DATA_W-1:0] RF_DATA
);

  localparam int CNT_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NREGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                last_b_q,   last_b_d;
  logic                rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]   rf_addr_q,  rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q,  rf_data_d;
  logic                a_ack_q,    a_ack_d;
  logic                b_ack_q,    b_ack_d;
  logic                clr_busy_q, clr_busy_d;

  logic                elig_a;
  logic                elig_b;
  logic                grant_a;
  logic                grant_b;
  logic                arb_en;
  logic [CNT_W-1:0]    cnt_nxt;

  // A requester whose ACK is on the port this cycle is still holding REQ; it must not win again.
  assign elig_a  = A_REQ & ~a_ack_q;
  assign elig_b  = B_REQ & ~b_ack_q;
  assign grant_a = elig_a & (~elig_b | last_b_q);
  assign grant_b = elig_b & (~elig_a | ~last_b_q);
  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_b_d   = last_b_q;
    rf_write_d = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    clr_busy_d = 1'b0;
    arb_en     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (CLR_REQ) begin
        state_d    = ST_CLEAR;
        cnt_d      = '0;
        rf_write_d = 1'b1;
        rf_addr_d  = '0;
        rf_data_d  = '0;
        clr_busy_d = 1'b1;
      end else begin
        arb_en = 1'b1;
      end
    end else begin
      // cnt_q is the address on the port this cycle; the edge ending the last
      // clear write already arbitrates so a waiting requester loses no cycle.
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        arb_en  = 1'b1;
      end else begin
        cnt_d      = cnt_nxt;
        rf_write_d = 1'b1;
        rf_addr_d  = ADDR_W'(cnt_nxt);
        rf_data_d  = '0;
        clr_busy_d = 1'b1;
      end
    end

    if (arb_en) begin
      if (grant_a) begin
        rf_write_d = 1'b1;
        rf_addr_d  = A_ADDR;
        rf_data_d  = A_DATA;
        a_ack_d    = 1'b1;
        last_b_d   = 1'b0;
      end else if (grant_b) begin
        rf_write_d = 1'b1;
        rf_addr_d  = B_ADDR;
        rf_data_d  = B_DATA;
        b_ack_d    = 1'b1;
        last_b_d   = 1'b1;
      end
    end
  end

  // LAST resets to B so that the first tie after reset goes to A.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      clr_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_b_q   <= last_b_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      clr_busy_q <= clr_busy_d;
    end
  end

  assign RF_WRITE = rf_write_q;
  assign RF_ADDR  = rf_addr_q;
  assign RF_DATA  = rf_data_q;
  assign A_ACK    = a_ack_q;
  assign B_ACK    = b_ack_q;
  assign CLR_BUSY = clr_busy_q;

  a_single_ack: assert property (@(posedge CLK) disable iff (!RESET) !(A_ACK && B_ACK));
  a_clr_no_ack: assert property (@(posedge CLK) disable iff (!RESET) !(CLR_BUSY && (A_ACK || B_ACK)));
  a_write_src:  assert property (@(posedge CLK) disable iff (!RESET) RF_WRITE == (A_ACK || B_ACK || CLR_BUSY));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CLR_REQ;
  logic          CLR_BUSY;
  logic          A_REQ;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_DATA;
  logic          A_ACK;
  logic          B_REQ;
  logic [AW-1:0] B_ADDR;
  logic [DW-1:0] B_DATA;
  logic          B_ACK;
  logic          RF_WRITE;
  logic [AW-1:0] RF_ADDR;
  logic [DW-1:0] RF_DATA;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .CLK(CLK), .RESET(RESET), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
    .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_ACK(B_ACK),
    .RF_WRITE(RF_WRITE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA)
  );

  always #5 CLK = ~CLK;

  // cyc = number of rising edges seen; a write caused by edge E is observed with cyc == E.
  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge CLK) begin
    cyc         <= cyc + 1;
    rst_at_edge <= RESET;
  end

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            src;   // 0 = A, 1 = B, 2 = clear
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;
  bit   started  = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  task automatic push(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d, input int s);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = d; e.src = s;
    exp_q.push_back(e);
  endtask

  // Requesters drop REQ as soon as their ACK is seen.
  task automatic step(input bit drop = 1'b1);
    @(posedge CLK);
    #1;
    if (drop) begin
      if (A_ACK) A_REQ = 1'b0;
      if (B_ACK) B_REQ = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic [2:0] flags;
    if (rst_at_edge == 1'b0) started = 1'b1;
    if (started) begin
      if (rst_at_edge == 1'b0) begin
        check("reset_outputs", 32'({RF_WRITE, RF_ADDR, RF_DATA, A_ACK, B_ACK, CLR_BUSY}), 32'd0);
        last_addr = '0;
        last_data = '0;
      end else if (RF_WRITE) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write at cycle %0d: addr %0d data 0x%0h, expected no write", cyc, RF_ADDR, RF_DATA);
        end else begin
          e = exp_q.pop_front();
          flags = (e.src == 0) ? 3'b100 : (e.src == 1) ? 3'b010 : 3'b001;
          check("write_cycle", 32'(cyc), 32'(e.cyc));
          check("write_addr", 32'(RF_ADDR), 32'(e.addr));
          check("write_data", 32'(RF_DATA), 32'(e.data));
          check("write_ack_busy", 32'({A_ACK, B_ACK, CLR_BUSY}), 32'(flags));
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("idle_ack_busy", 32'({A_ACK, B_ACK, CLR_BUSY}), 32'd0);
        check("idle_hold", 32'({RF_ADDR, RF_DATA}), 32'({last_addr, last_data}));
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_write at cycle %0d: no write seen, expected addr %0d data 0x%0h at cycle %0d",
                 cyc, e.addr, e.data, e.cyc);
      end
    end
    if (done) begin
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    int c0;
    RESET = 1'b0; CLR_REQ = 1'b0;
    A_REQ = 1'b0; A_ADDR = '0; A_DATA = '0;
    B_REQ = 1'b0; B_ADDR = '0; B_DATA = '0;
    repeat (3) step();

    // Single A request released together with reset.
    RESET = 1'b1; A_REQ = 1'b1; A_ADDR = 3'd3; A_DATA = 8'h5A;
    push(cyc + 1, 3'd3, 8'h5A, 0);
    repeat (4) step();

    // Ties from reset: A first, then B; second tie goes to A again.
    RESET = 1'b0;
    repeat (2) step();
    RESET = 1'b1;
    A_REQ = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h11;
    B_REQ = 1'b1; B_ADDR = 3'd5; B_DATA = 8'h22;
    push(cyc + 1, 3'd2, 8'h11, 0);
    push(cyc + 2, 3'd5, 8'h22, 1);
    repeat (4) step();
    A_REQ = 1'b1; A_DATA = 8'h33;
    B_REQ = 1'b1; B_DATA = 8'h44;
    push(cyc + 1, 3'd2, 8'h33, 0);
    push(cyc + 2, 3'd5, 8'h44, 1);
    repeat (4) step();

    // Continuous requests alternate A,B,A,B with a write every cycle.
    A_REQ = 1'b1; A_ADDR = 3'd6; A_DATA = 8'hA6;
    B_REQ = 1'b1; B_ADDR = 3'd1; B_DATA = 8'hB1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(cyc + 1 + i, 3'd6, 8'hA6, 0);
      else            push(cyc + 1 + i, 3'd1, 8'hB1, 1);
    end
    repeat (6) step(1'b0);
    A_REQ = 1'b0; B_REQ = 1'b0;
    repeat (2) step();

    // One-cycle clear pulse: addresses 0..7 zeroed back to back.
    CLR_REQ = 1'b1;
    for (int i = 0; i < NR; i++) push(cyc + 1 + i, AW'(i), 8'h00, 2);
    step();
    CLR_REQ = 1'b0;
    repeat (9) step();

    // B arrives at clear cycle 3 (with a stray CLR_REQ); served right after the clear.
    CLR_REQ = 1'b1; c0 = cyc;
    for (int i = 0; i < NR; i++) push(c0 + 1 + i, AW'(i), 8'h00, 2);
    step();
    CLR_REQ = 1'b0;
    repeat (3) step();
    B_REQ = 1'b1; B_ADDR = 3'd7; B_DATA = 8'h99; CLR_REQ = 1'b1;
    push(c0 + 9, 3'd7, 8'h99, 1);
    step();
    CLR_REQ = 1'b0;
    repeat (6) step();

    // Clear and A at the same edge: clear first, A after address 7.
    CLR_REQ = 1'b1; A_REQ = 1'b1; A_ADDR = 3'd4; A_DATA = 8'hC3; c0 = cyc;
    for (int i = 0; i < NR; i++) push(c0 + 1 + i, AW'(i), 8'h00, 2);
    push(c0 + 9, 3'd4, 8'hC3, 0);
    step();
    CLR_REQ = 1'b0;
    repeat (10) step();

    // Reset during clear cycle 4 aborts the sequence.
    CLR_REQ = 1'b1; c0 = cyc;
    for (int i = 0; i < 5; i++) push(c0 + 1 + i, AW'(i), 8'h00, 2);
    step();
    CLR_REQ = 1'b0;
    repeat (4) step();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    repeat (4) step();

    // Reset dominates requests at a would-be grant edge; both re-arbitrate after release.
    A_REQ = 1'b1; A_ADDR = 3'd1; A_DATA = 8'h77;
    B_REQ = 1'b1; B_ADDR = 3'd2; B_DATA = 8'h88;
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    push(cyc + 1, 3'd1, 8'h77, 0);
    push(cyc + 2, 3'd2, 8'h88, 1);
    repeat (5) step();

    done = 1'b1;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, register data width; ADDR_W, 3, register address width; NREGS, 8, registers cleared by the clear sequence.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-004 CLR_REQ  input  1  request a sequenced zeroing of all NREGS registers.
REQ-005 CLR_BUSY  output  1  high while the clear sequence issues writes.
REQ-006 A_REQ  input  1  requester A (ALU writeback) write request.
REQ-007 A_ADDR  input  ADDR_W  requester A destination register.
REQ-008 A_DATA  input  DATA_W  requester A write data.
REQ-009 A_ACK  output  1  one-cycle pulse: A's write is on the register-file port this cycle.
REQ-010 B_REQ, B_ADDR, B_DATA, B_ACK SHALL mirror REQ-006..009 for requester B (load unit).
REQ-011 RF_WRITE  output  1  write enable to the register file.
REQ-012 RF_ADDR  output  ADDR_W  write address to the register file.
REQ-013 RF_DATA  output  DATA_W  write data to the register file.

Function
REQ-014 States SHALL be IDLE and CLEAR; all outputs SHALL be registered (no combinational input-to-output path).
REQ-015 IDLE, CLR_REQ=1 at edge k -> CLEAR, counter=0; CLR_REQ SHALL take priority over A_REQ/B_REQ at that edge.
REQ-016 CLEAR: cycle k+1+i (i=0..NREGS-1) SHALL drive RF_WRITE=1, RF_ADDR=i, RF_DATA=0, CLR_BUSY=1.
REQ-017 After the write with RF_ADDR=NREGS-1, the FSM SHALL return to IDLE; CLR_BUSY=0 from the next cycle.
REQ-018 CLR_REQ during CLEAR SHALL be ignored (no restart, no extension).
REQ-019 A/B requests during CLEAR SHALL remain pending, unacknowledged; arbitration resumes at the first IDLE edge.
REQ-020 A requester SHALL be eligible at edge k if its REQ=1 and its ACK=0 in the cycle ending at k.
REQ-021 IDLE, exactly one eligible requester at edge k -> it SHALL be granted.
REQ-022 IDLE, both eligible -> grant the requester not granted most recently (round-robin LAST pointer).
REQ-023 Grant at edge k: in cycle k+1, RF_WRITE=1, RF_ADDR/RF_DATA = granted requester's ADDR/DATA sampled at edge k, its ACK=1.
REQ-024 Granted requester's ACK SHALL be high for exactly one cycle; LAST SHALL update at the grant edge.
REQ-025 Requesters SHALL hold REQ/ADDR/DATA stable until ACK; write latency is exactly 1 cycle from grant edge to RF_WRITE.
REQ-026 No grant at edge k -> cycle k+1 SHALL have RF_WRITE=0, A_ACK=0, B_ACK=0; RF_ADDR/RF_DATA hold previous values.
REQ-027 Invariants: A_ACK&B_ACK=0; CLR_BUSY&(A_ACK|B_ACK)=0; RF_WRITE = A_ACK|B_ACK|CLR_BUSY.
REQ-028 With both requesters continuously requesting, grants SHALL alternate A,B,A,B with RF_WRITE=1 every cycle.

Reset
REQ-029 RESET=0 at an edge SHALL force: state IDLE, counter 0, LAST=B, and RF_WRITE, RF_ADDR, RF_DATA, A_ACK, B_ACK, CLR_BUSY all 0 in the next cycle.
REQ-030 RESET=0 mid-CLEAR or on a grant edge SHALL abort: no write, no ACK issued afterwards; pending requests re-arbitrate after release.
REQ-031 RESET SHALL dominate CLR_REQ, A_REQ and B_REQ at the same edge.

Verification
REQ-032 Reset release, A_REQ=1, A_ADDR=3, A_DATA=0x5A -> next cycle RF_WRITE=1, RF_ADDR=3, RF_DATA=0x5A, A_ACK=1 for one cycle only.
REQ-033 From reset, A and B both request (A:2/0x11, B:5/0x22), held -> A written first, then B on next cycle; second tie after both drop and reassert -> A again (LAST=B).
REQ-034 CLR_REQ one-cycle pulse -> 8 consecutive cycles RF_WRITE=1, RF_ADDR 0..7, RF_DATA=0, CLR_BUSY=1; then CLR_BUSY=0.
REQ-035 B_REQ raised at clear cycle 3 with B_ADDR=7/0x99 -> no B_ACK until CLEAR ends; B write in first cycle after CLR_BUSY falls.
REQ-036 CLR_REQ and A_REQ at same edge -> clear runs first, A acknowledged after address 7 cleared.
REQ-037 RESET=0 during clear cycle 4 -> no further RF_WRITE; CLR_BUSY=0; all outputs 0 next cycle.
